// File: rtl/log_capture_mem.sv
// Capture buffer: logs consecutive valid DSP samples into block RAM on a run_log rising edge
// until DEPTH words are stored, then serves registered (latency 1, read-first) readback by address.
module log_capture_mem #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_run_log,
  input  logic               i_read_log,
  input  logic [NB_ADDR-1:0] i_addr_log_to_mem,
  input  logic [NB_DATA-1:0] i_data_log,
  input  logic               i_data_valid,
  output logic [NB_DATA-1:0] o_data_log_from_mem,
  output logic               o_mem_full,
  output logic               o_log_busy
);

  localparam int DEPTH = 2 ** NB_ADDR;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [1:0]         state;
  logic [NB_ADDR-1:0] wr_ptr;
  logic               run_log_d;
  logic               run_start;
  logic               wr_en;

  logic [NB_DATA-1:0] mem [0:DEPTH-1];

  assign run_start = i_run_log & ~run_log_d;
  assign wr_en     = ~i_rst & ~run_start & (state == ST_CAPTURE) & i_data_valid;

  // Keeps sampling through reset, so a command level held across reset
  // release is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    run_log_d <= i_run_log;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      o_mem_full <= 1'b0;
      o_log_busy <= 1'b0;
    end else if (run_start) begin
      state      <= ST_CAPTURE;
      wr_ptr     <= '0;
      o_mem_full <= 1'b0;
      o_log_busy <= 1'b1;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (i_data_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == '1) begin
              state      <= ST_FULL;
              o_mem_full <= 1'b1;
              o_log_busy <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          o_mem_full <= 1'b1;
          o_log_busy <= 1'b0;
        end
        ST_IDLE: begin
          o_mem_full <= 1'b0;
          o_log_busy <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          o_mem_full <= 1'b0;
          o_log_busy <= 1'b0;
        end
      endcase
    end
  end

  // Single write port and registered read port, kept in separate blocks for BRAM mapping.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_data_log;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_data_log_from_mem <= '0;
    end else if (i_read_log) begin
      o_data_log_from_mem <= mem[i_addr_log_to_mem];
    end
  end

endmodule

// File: tb/tb_log_capture_mem.sv
// Randomised and directed bench for log_capture_mem (DEPTH=16): a reference model pushes the
// expected per-cycle outputs into a queue and an independent negedge monitor pops and compares.
module tb_log_capture_mem;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 4;
  localparam int DEPTH   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               run_log = 1'b0;
  logic               read_log = 1'b0;
  logic [NB_ADDR-1:0] addr = '0;
  logic [NB_DATA-1:0] din = '0;
  logic               dvld = 1'b0;
  logic [NB_DATA-1:0] dout;
  logic               full;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  log_capture_mem #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .clk                 (clk),
    .i_rst               (rst),
    .i_run_log           (run_log),
    .i_read_log          (read_log),
    .i_addr_log_to_mem   (addr),
    .i_data_log          (din),
    .i_data_valid        (dvld),
    .o_data_log_from_mem (dout),
    .o_mem_full          (full),
    .o_log_busy          (busy)
  );

  typedef struct {
    logic [NB_DATA-1:0] d;
    bit                 dk;
    bit                 f;
    bit                 b;
    int                 cyc;
  } exp_t;

  exp_t q[$];

  // Reference model: buffer contents, how many samples logged, and capture/full flags.
  logic [NB_DATA-1:0] m_mem [DEPTH];
  bit                 m_known [DEPTH];
  bit                 m_prev = 1'b0;
  bit                 m_cap = 1'b0;
  bit                 m_full = 1'b0;
  int                 m_count = 0;
  logic [NB_DATA-1:0] m_rd = '0;
  bit                 m_rdk = 1'b0;

  task automatic model_edge(input bit r, input bit run, input bit rd,
                            input int a, input logic [NB_DATA-1:0] d, input bit v);
    bit start;
    start  = run && !m_prev;
    m_prev = run;
    if (r) begin
      m_cap = 0; m_full = 0; m_count = 0; m_rd = '0; m_rdk = 1;
    end else begin
      if (rd) begin
        m_rd  = m_mem[a];
        m_rdk = m_known[a];
      end
      if (start) begin
        m_cap = 1; m_full = 0; m_count = 0;
      end else if (m_cap && v) begin
        m_mem[m_count]   = d;
        m_known[m_count] = 1;
        m_count++;
        if (m_count == DEPTH) begin
          m_cap = 0; m_full = 1; m_count = 0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit run, input bit rd, input int a,
                      input logic [NB_DATA-1:0] d, input bit v);
    exp_t e;
    rst = r; run_log = run; read_log = rd; addr = NB_ADDR'(a); din = d; dvld = v;
    @(posedge clk);
    cyc++;
    model_edge(r, run, rd, a, d, v);
    e.d = m_rd; e.dk = m_rdk; e.f = m_full; e.b = m_cap; e.cyc = cyc;
    q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic readback(input int a);
    step(0, 0, 1, a, '0, 0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (full !== e.f) begin
        errors++;
        $display("FAIL mem_full cyc %0d: got %b want %b", e.cyc, full, e.f);
      end
      checks++;
      if (busy !== e.b) begin
        errors++;
        $display("FAIL log_busy cyc %0d: got %b want %b", e.cyc, busy, e.b);
      end
      if (e.dk) begin
        checks++;
        if (dout !== e.d) begin
          errors++;
          $display("FAIL read_data cyc %0d: got %h want %h", e.cyc, dout, e.d);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 0;
    end

    step(1, 0, 0, 0, '0, 0);
    step(1, 0, 0, 0, '0, 0);

    // Idle with valid data: nothing captured, outputs stay at reset values.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, $urandom, 1);

    // Full capture with valid every cycle, then full readback.
    step(0, 1, 0, 0, '0, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, 32'h100 + k, 1);
    idle(2);
    for (int k = 0; k < DEPTH; k++) readback(k);

    // Reset, then valid in idle must not disturb the stored log.
    step(1, 0, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'hBAD0 + i, 1);
    for (int k = 0; k < DEPTH; k++) readback(k);

    // Sparse valid (every 3rd cycle); extra samples after full are ignored.
    step(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < 200 && !m_full; i++) step(0, 0, 0, 0, 32'h200 + i, (i % 3) == 2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 32'hDEAD0000 + i, 1);
    readback(15);
    readback(0);

    // Restart from FULL with a valid sample on the command cycle.
    step(0, 1, 0, 0, 32'h3AA, 1);
    step(0, 0, 0, 0, '0, 0);
    step(0, 0, 0, 0, 32'h3BB, 1);
    readback(0);
    readback(1);

    // Reset after five writes, command held high through reset release.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h400 + i, 1);
    step(1, 1, 0, 0, '0, 1);
    step(1, 1, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'h500 + i, 1);
    step(0, 0, 0, 0, '0, 0);
    for (int k = 0; k < 6; k++) readback(k);

    // Output holds when read disabled; same-address read/write returns old data.
    readback(3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, i * 3 + 1, '0, 0);
    step(0, 1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h600 + i, 1);
    step(0, 0, 1, m_count, 32'h6FF, 1);
    readback(m_count - 1);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
           $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom, $urandom_range(0, 3) != 0);
    end
    idle(3);
    for (int k = 0; k < DEPTH; k++) readback(k);
    idle(2);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
